// File: rtl/ext_msg_pkg.sv
// Shared types and constants for the ext_msg debug message path.
// Used by the arbiter, its FIFO and the message sink.
package ext_msg_pkg;

    localparam int MSG_CODE_W = 1;
    localparam int MSG_SRC_W  = 2;

    // Sink writes its text to this descriptor.
    localparam int STDERR = 32'h8000_0002;

    typedef struct packed {
        logic [MSG_SRC_W-1:0]  src;
        logic [MSG_CODE_W-1:0] code;
    } msg_entry_t;

endpackage

// File: rtl/ext_msg_arbiter_if.sv
// Requester / sink bundle of the ext_msg arbiter.
// slave = arbiter view, master = environment view.
interface ext_msg_arbiter_if
    import ext_msg_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int CODE_W = MSG_CODE_W,
    parameter int DEPTH  = 4,
    parameter int SRC_W  = $clog2(N_REQ)
);

    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*CODE_W-1:0]   req_code;
    logic [N_REQ-1:0]          req_ready;
    logic [CODE_W:0]           msg_arg;
    logic [SRC_W-1:0]          msg_src;
    logic                      sink_ready;
    logic [$clog2(DEPTH):0]    fifo_level;
    logic [15:0]               sent_count;

    modport slave (
        input  req_valid,
        input  req_code,
        input  sink_ready,
        output req_ready,
        output msg_arg,
        output msg_src,
        output fifo_level,
        output sent_count
    );

    modport master (
        output req_valid,
        output req_code,
        output sink_ready,
        input  req_ready,
        input  msg_arg,
        input  msg_src,
        input  fifo_level,
        input  sent_count
    );

endinterface

// File: rtl/ext_msg_arbiter_msg_fifo.sv
// Small circular FIFO holding accepted messages.
// Pushes into a full FIFO and pops from an empty one are ignored.
module msg_fifo
    import ext_msg_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = msg_entry_t
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   push,
    input  T                       wr_data,
    input  logic                   pop,
    output T                       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    level_q;
    logic           do_push;
    logic           do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = level_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (
        @(posedge CLK) disable iff (!RST_N)
        !(push && full));
`endif

endmodule

// File: rtl/ext_msg_arbiter.sv
// Round-robin arbiter sharing one ext_msg sink among N requesters,
// with a small FIFO between the grant and the sink.
module ext_msg_arbiter
    import ext_msg_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int CODE_W = MSG_CODE_W,
    parameter int DEPTH  = 4,
    parameter int SRC_W  = $clog2(N_REQ)
) (
    input logic              CLK,
    input logic              RST_N,
    ext_msg_arbiter_if.slave bus
);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [CODE_W-1:0] code;
    } entry_t;

    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       gnt_idx;
    logic [SRC_W-1:0]       cand;
    logic [N_REQ-1:0]       gnt;
    logic                   hit;
    int                     idx;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    entry_t                 wr_e;
    entry_t                 head;
    logic [15:0]            sent_q;
    logic [$clog2(DEPTH):0] level;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        hit     = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = SRC_W'(idx);
            if (!hit && bus.req_valid[cand]) begin
                hit     = 1'b1;
                gnt_idx = cand;
            end
        end
        if (hit && RST_N && !full) gnt[gnt_idx] = 1'b1;
    end

    assign push      = |gnt;
    assign pop       = !empty && bus.sink_ready;
    assign wr_e.src  = gnt_idx;
    assign wr_e.code =
        bus.req_code[int'(gnt_idx)*CODE_W +: CODE_W];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rr_ptr <= '0;
            sent_q <= '0;
        end else begin
            if (push) begin
                rr_ptr <= (gnt_idx == SRC_W'(N_REQ-1))
                        ? '0 : gnt_idx + 1'b1;
            end
            if (pop) sent_q <= sent_q + 16'd1;
        end
    end

    msg_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push    (push),
        .wr_data (wr_e),
        .pop     (pop),
        .rd_data (head),
        .level   (level),
        .empty   (empty),
        .full    (full)
    );

    assign bus.req_ready  = gnt;
    assign bus.msg_arg    = empty ? '0 : {1'b1, head.code};
    assign bus.msg_src    = empty ? '0 : head.src;
    assign bus.fifo_level = level;
    assign bus.sent_count = sent_q;

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (
        @(posedge CLK) $onehot0(gnt));
`endif

endmodule

// File: tb/tb_ext_msg_arbiter.sv
// Scoreboard bench for ext_msg_arbiter (N_REQ=4, CODE_W=1, DEPTH=4).
// Expected messages are queued on grant and compared at the sink.
module tb_ext_msg_arbiter;

    localparam int N = 4;
    localparam int D = 4;

    typedef struct {
        int src;
        int code;
    } exp_t;

    logic CLK;
    logic RST_N;
    logic mon_en;

    int n_tests;
    int n_fail;
    int pops;
    int rr_m;
    int sent_m;
    exp_t q[$];

    ext_msg_arbiter_if #(
        .N_REQ  (N),
        .CODE_W (1),
        .DEPTH  (D)
    ) bus ();

    ext_msg_arbiter #(
        .N_REQ  (N),
        .CODE_W (1),
        .DEPTH  (D)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: grant, queue contents, level and count.
    always @(negedge CLK) begin
        int g;
        int ix;
        logic [31:0] eg;
        exp_t e;
        if (mon_en) begin
            g  = -1;
            eg = 0;
            if (RST_N && q.size() < D) begin
                for (int i = 0; i < N; i++) begin
                    ix = (rr_m + i) % N;
                    if (g < 0 && bus.req_valid[ix]) g = ix;
                end
            end
            if (g >= 0) eg = 32'd1 << g;
            check("m_grant", bus.req_ready, eg);
            check("m_level", bus.fifo_level, q.size());
            check("m_sent", bus.sent_count, sent_m);
            if (q.size() == 0) begin
                check("m_arg_idle", bus.msg_arg, 0);
            end else begin
                check("m_arg", bus.msg_arg, 2 + q[0].code);
                check("m_src", bus.msg_src, q[0].src);
            end
            if (!RST_N) begin
                q.delete();
                rr_m   = 0;
                sent_m = 0;
            end else begin
                if (q.size() > 0 && bus.sink_ready) begin
                    void'(q.pop_front());
                    sent_m = (sent_m + 1) % 65536;
                    pops++;
                end
                if (g >= 0) begin
                    e.src  = g;
                    e.code = int'(bus.req_code[g]);
                    q.push_back(e);
                    rr_m = (g + 1) % N;
                end
            end
        end
    end

    initial begin
        int c;
        n_tests = 0;
        n_fail  = 0;
        pops    = 0;
        rr_m    = 0;
        sent_m  = 0;
        mon_en  = 1'b0;
        RST_N   = 1'b0;
        bus.req_valid  = 4'b1111;
        bus.req_code   = 4'b1010;
        bus.sink_ready = 1'b1;

        // Reset held with all requesters valid
        @(posedge CLK);
        #1 mon_en = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("rst_ready", bus.req_ready, 0);
        end
        check("rst_arg", bus.msg_arg, 0);
        check("rst_src", bus.msg_src, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_sent", bus.sent_count, 0);

        // Round-robin with all valid
        step();
        RST_N = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check("rr_grant", bus.req_ready, 1 << (k % 4));
            if (k > 0) begin
                check("rr_src", bus.msg_src, (k - 1) % 4);
                check("rr_arg", bus.msg_arg,
                      ((k - 1) % 2 == 1) ? 3 : 2);
            end
            step();
        end
        bus.req_valid = 4'b0000;
        repeat (3) step();

        RST_N = 1'b0;
        step();
        RST_N = 1'b1;

        // Backpressure fill
        bus.sink_ready = 1'b0;
        bus.req_valid  = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            check("bp_grant", bus.req_ready, (k < 4) ? 1 : 0);
            step();
        end
        @(negedge CLK);
        check("bp_full", bus.fifo_level, 4);
        step();

        // Drain one per cycle
        bus.sink_ready = 1'b1;
        bus.req_valid  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("drain_lvl", bus.fifo_level, 4 - k);
            step();
        end
        @(negedge CLK);
        check("drain_empty", bus.fifo_level, 0);
        check("drain_sent", bus.sent_count, 4);
        check("drain_arg", bus.msg_arg, 0);

        // Refill, then pop and push in the same full cycle
        bus.sink_ready = 1'b0;
        bus.req_valid  = 4'b0001;
        repeat (4) step();
        bus.sink_ready = 1'b1;
        bus.req_valid  = 4'b0100;
        @(negedge CLK);
        check("fp_lvl4", bus.fifo_level, 4);
        check("fp_nogrant", bus.req_ready, 0);
        step();
        @(negedge CLK);
        check("fp_lvl3", bus.fifo_level, 3);
        check("fp_grant", bus.req_ready, 4'b0100);
        step();
        bus.sink_ready = 1'b0;
        bus.req_valid  = 4'b0000;
        @(negedge CLK);
        check("fp_hold3", bus.fifo_level, 3);
        step();

        // Reset mid-operation; rr_ptr was 3
        RST_N = 1'b0;
        bus.req_valid = 4'b1100;
        @(negedge CLK);
        check("mr_ready", bus.req_ready, 0);
        step();
        RST_N = 1'b1;
        @(negedge CLK);
        check("mr_level", bus.fifo_level, 0);
        check("mr_arg", bus.msg_arg, 0);
        check("mr_grant", bus.req_ready, 4'b0100);
        step();

        // sent_count wrap after 65536 deliveries
        RST_N = 1'b0;
        bus.req_valid = 4'b0000;
        pops = 0;
        step();
        RST_N = 1'b1;
        bus.sink_ready = 1'b1;
        bus.req_valid  = 4'b0001;
        c = 0;
        while (pops < 65536 && c < 70000) begin
            @(posedge CLK);
            c++;
        end
        check("wrap_pops", pops, 65536);
        #1;
        bus.sink_ready = 1'b0;
        bus.req_valid  = 4'b0000;
        @(negedge CLK);
        check("wrap_sent", bus.sent_count, 0);
        check("wrap_level", bus.fifo_level, 1);
        check("wrap_src", bus.msg_src, 0);
        step();

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
